// File: rtl/ch_arb_pkg.sv
// Shared types and helpers for the channel read arbiter and the round-robin picker.
package ch_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        HDR,
        LOAD,
        GRANT,
        POP,
        SETTLE
    } state_t;

    localparam logic [7:0]  HEADER_MAGIC = 8'hA5;
    localparam int unsigned BURST_CNT_W  = 8;

    // Channel index width; never narrower than one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/channel_read_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first non-empty channel after ptr.
module rr_pick
    import ch_arb_pkg::*;
#(
    parameter  int unsigned N_CH = 4,
    localparam int unsigned IW   = ch_idx_w(N_CH)
) (
    input  logic [N_CH-1:0] empty,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand;

    // Scan ptr+1 .. ptr+N_CH (wrapping); the first hit wins, ptr itself is checked last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned off = 1; off <= N_CH; off++) begin
            cand = IW'((32'(ptr) + off) % N_CH);
            if (!found && !empty[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/channel_read_arbiter.sv
// Round-robin burst arbiter sharing the uController uplink among N_CH show-ahead FIFOs.
// Optional per-grant header word enabled by defining CH_ARB_HEADER_EN.
module channel_read_arbiter
    import ch_arb_pkg::*;
#(
    parameter  int unsigned N_CH      = 4,
    parameter  int unsigned DATA_W    = 16,
    parameter  int unsigned BURST_LEN = 8,
    localparam int unsigned IW        = ch_idx_w(N_CH)
) (
    input  logic                   SYS_CLK,
    input  logic                   RST,
    input  logic                   ON,
    input  logic [N_CH-1:0]        CH_EMPTY,
    input  logic [N_CH*DATA_W-1:0] CH_DATA,
    output logic [N_CH-1:0]        CH_READ_REQ,
    output logic                   UC_CHANNEL_EMPTY,
    output logic [DATA_W-1:0]      UC_CHANNEL_DATA,
    input  logic                   UC_FIN_EDGE,
    output logic [IW-1:0]          ACTIVE_CH,
    output logic                   BUSY
);

    if (N_CH < 2 || N_CH > 8) begin : g_bad_nch
        $error("channel_read_arbiter: N_CH must be 2..8");
    end
    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst
        $error("channel_read_arbiter: BURST_LEN must be 1..255");
    end
`ifdef CH_ARB_HEADER_EN
    if (DATA_W != 16) begin : g_bad_hdr_w
        $error("channel_read_arbiter: header mode requires DATA_W == 16");
    end
`endif

    state_t                 state, state_nxt;
    logic [BURST_CNT_W-1:0] burst_cnt, burst_nxt;
    logic [IW-1:0]          rr_ptr, rr_nxt;
    logic [IW-1:0]          active_nxt;
    logic [N_CH-1:0]        read_req_nxt;
    logic                   uc_empty_nxt;
    logic [DATA_W-1:0]      uc_data_nxt;
    logic                   busy_nxt;
    logic                   pick_found;
    logic [IW-1:0]          pick_idx;
    logic [DATA_W-1:0]      ch_word [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_word
        assign ch_word[k] = CH_DATA[k*DATA_W +: DATA_W];
    end

    rr_pick #(.N_CH(N_CH)) u_pick (
        .empty (CH_EMPTY),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_nxt    = state;
        burst_nxt    = burst_cnt;
        rr_nxt       = rr_ptr;
        active_nxt   = ACTIVE_CH;
        read_req_nxt = '0;
        uc_empty_nxt = UC_CHANNEL_EMPTY;
        uc_data_nxt  = UC_CHANNEL_DATA;
        unique case (state)
            IDLE: begin
                uc_empty_nxt = 1'b1;
                if (ON) state_nxt = SELECT;
            end
            SELECT: begin
                uc_empty_nxt = 1'b1;
                if (!ON) begin
                    state_nxt = IDLE;
                end else if (pick_found) begin
                    active_nxt = pick_idx;
                    rr_nxt     = pick_idx;
                    burst_nxt  = '0;
`ifdef CH_ARB_HEADER_EN
                    uc_data_nxt  = DATA_W'({HEADER_MAGIC, 8'(pick_idx)});
                    uc_empty_nxt = 1'b0;
                    state_nxt    = HDR;
`else
                    state_nxt    = LOAD;
`endif
                end
            end
`ifdef CH_ARB_HEADER_EN
            HDR: begin
                if (UC_FIN_EDGE) begin
                    uc_empty_nxt = 1'b1;
                    state_nxt    = LOAD;
                end
            end
`endif
            LOAD: begin
                uc_data_nxt  = ch_word[ACTIVE_CH];
                uc_empty_nxt = 1'b0;
                state_nxt    = GRANT;
            end
            // The word stays offered regardless of ON until uController finishes it.
            GRANT: begin
                if (UC_FIN_EDGE) begin
                    uc_empty_nxt = 1'b1;
                    read_req_nxt = N_CH'(1) << ACTIVE_CH;
                    state_nxt    = POP;
                end
            end
            POP: begin
                burst_nxt = burst_cnt + BURST_CNT_W'(1);
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (!ON)
                    state_nxt = IDLE;
                else if (burst_cnt < BURST_CNT_W'(BURST_LEN) && !CH_EMPTY[ACTIVE_CH])
                    state_nxt = LOAD;
                else
                    state_nxt = SELECT;
            end
            default: begin
                uc_empty_nxt = 1'b1;
                state_nxt    = IDLE;
            end
        endcase
        busy_nxt = !(state_nxt == IDLE || state_nxt == SELECT);
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state            <= IDLE;
            burst_cnt        <= '0;
            rr_ptr           <= IW'(N_CH - 1);
            ACTIVE_CH        <= '0;
            CH_READ_REQ      <= '0;
            UC_CHANNEL_EMPTY <= 1'b1;
            UC_CHANNEL_DATA  <= '0;
            BUSY             <= 1'b0;
        end else begin
            state            <= state_nxt;
            burst_cnt        <= burst_nxt;
            rr_ptr           <= rr_nxt;
            ACTIVE_CH        <= active_nxt;
            CH_READ_REQ      <= read_req_nxt;
            UC_CHANNEL_EMPTY <= uc_empty_nxt;
            UC_CHANNEL_DATA  <= uc_data_nxt;
            BUSY             <= busy_nxt;
        end
    end

endmodule
